// File: rtl/fft32_pkg.sv
// Shared constants, bin-index bit reversal and FSM state encoding for the 32-point FFT
// output reorder path.
package fft32_pkg;
   localparam int N     = 32;
   localparam int HALF  = N / 2;
   localparam int LOG2N = 5;
   localparam int AW    = LOG2N - 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WRITE,
      S_READ
   } fsm_state_t;

   // 5-bit reversal of 2j collapses to a 4-bit reversal of j, because the dropped LSB is 0.
   function automatic logic [AW-1:0] rev4(input logic [AW-1:0] j);
      logic [AW-1:0] r;
      for (int i = 0; i < AW; i++) r[i] = j[AW-1-i];
      return r;
   endfunction
endpackage

// File: rtl/fft_pp_half_bank.sv
// One half (lo or hi) of a ping-pong bank: 16 words, synchronous write port and
// registered read port. The read port returns 0 when it is not enabled.
module fft_pp_half_bank
   import fft32_pkg::*;
#(
   parameter int W = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);
   logic [W-1:0] mem [HALF];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  rdata <= '0;
      else if (re) rdata <= mem[raddr];
      else         rdata <= '0;
   end
endmodule

// File: rtl/fft_output_reorder.sv
// Reorders the bit-reversed MDC FFT output pairs into natural-order (X[k], X[k+16]) pairs
// using two ping-pong banks.
//   state   | meaning
//   S_IDLE  | write: waiting for in_start / read: no finished frame to stream
//   S_WRITE | capturing samples j=1..15 of a frame (j=0 is taken on the in_start cycle)
//   S_READ  | streaming k=0..15 from the finished bank
module fft_output_reorder
   import fft32_pkg::*;
#(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_start,
   input  logic [2*DW-1:0] in_a,
   input  logic [2*DW-1:0] in_b,
   output logic          out_valid,
   output logic [2*DW-1:0] out_lo,
   output logic [2*DW-1:0] out_hi,
   output logic          out_first,
   output logic          out_last,
   output logic          frame_err
);
   localparam int W = 2 * DW;

   fsm_state_t    wr_state;
   fsm_state_t    rd_state;
   logic [AW-1:0] wr_j;
   logic [AW-1:0] rd_k;
   logic          wr_bank;
   logic          rd_bank;
   logic          abort;
   logic          wr_en;
   logic          frame_done;
   logic          rd_en;
   logic [AW-1:0] wr_addr;
   logic [1:0][W-1:0] lo_q;
   logic [1:0][W-1:0] hi_q;

   // in_start always begins a frame at j=0; inside S_WRITE it also discards the partial one.
   assign abort      = in_start && (wr_state == S_WRITE);
   assign wr_en      = in_start || (wr_state == S_WRITE);
   assign wr_addr    = rev4(in_start ? AW'(0) : wr_j);
   assign frame_done = !in_start && (wr_state == S_WRITE) && (wr_j == AW'(HALF - 1));
   assign rd_en      = (rd_state == S_READ);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_state  <= S_IDLE;
         wr_j      <= '0;
         wr_bank   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= abort;
         if (in_start) begin
            wr_state <= S_WRITE;
            wr_j     <= AW'(1);
         end else if (frame_done) begin
            wr_state <= S_IDLE;
            wr_j     <= '0;
            wr_bank  <= ~wr_bank;
         end else if (wr_state == S_WRITE) begin
            wr_j <= wr_j + AW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_state  <= S_IDLE;
         rd_k      <= '0;
         rd_bank   <= 1'b0;
         out_valid <= 1'b0;
         out_first <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         out_valid <= rd_en;
         out_first <= rd_en && (rd_k == AW'(0));
         out_last  <= rd_en && (rd_k == AW'(HALF - 1));
         if (frame_done) begin
            rd_state <= S_READ;
            rd_k     <= '0;
            rd_bank  <= wr_bank;
         end else if (rd_en) begin
            if (rd_k == AW'(HALF - 1)) rd_state <= S_IDLE;
            rd_k <= rd_k + AW'(1);
         end
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      fft_pp_half_bank #(.W(W)) u_lo (
         .clk   (clk),
         .rst_n (rst_n),
         .we    (wr_en && (wr_bank == 1'(b))),
         .waddr (wr_addr),
         .wdata (in_a),
         .re    (rd_en && (rd_bank == 1'(b))),
         .raddr (rd_k),
         .rdata (lo_q[b])
      );
      fft_pp_half_bank #(.W(W)) u_hi (
         .clk   (clk),
         .rst_n (rst_n),
         .we    (wr_en && (wr_bank == 1'(b))),
         .waddr (wr_addr),
         .wdata (in_b),
         .re    (rd_en && (rd_bank == 1'(b))),
         .raddr (rd_k),
         .rdata (hi_q[b])
      );
   end

   // Idle read ports return 0, so OR-ing both banks is a mux that also zeroes invalid cycles.
   assign out_lo = lo_q[0] | lo_q[1];
   assign out_hi = hi_q[0] | hi_q[1];
endmodule

// File: tb/tb_fft_output_reorder.sv
// Scoreboard bench for fft_output_reorder: a frame-level model collects 16 samples per frame,
// places them at their natural bin index and queues the expected natural-order stream.
module tb_fft_output_reorder;
   localparam int DW = 16;
   localparam int W  = 2 * DW;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_start = 1'b0;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic         out_valid, out_first, out_last, frame_err;
   logic [W-1:0] out_lo, out_hi;

   typedef struct {
      int           cyc;
      logic [W-1:0] lo;
      logic [W-1:0] hi;
      bit           first;
      bit           last;
   } exp_t;

   exp_t         exp_q[$];
   int           err_q[$];
   exp_t         mon_e;
   int           n_tests = 0;
   int           n_fail  = 0;
   int           cur_cyc = 0;
   int           m_len   = 0;
   int           m_start = 0;
   logic [W-1:0] m_bins [32];

   always #5 clk = ~clk;

   fft_output_reorder #(.DW(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_start  (in_start),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_lo    (out_lo),
      .out_hi    (out_hi),
      .out_first (out_first),
      .out_last  (out_last),
      .frame_err (frame_err)
   );

   // Natural bin index of MDC output sample s (s = 2j for in_a, 2j+1 for in_b).
   function automatic int nat_index(int s);
      int r = 0;
      for (int i = 0; i < 5; i++) if (((s >> i) & 1) == 1) r |= (1 << (4 - i));
      return r;
   endfunction

   task automatic model_step(bit s, logic [W-1:0] a, logic [W-1:0] b);
      exp_t e;
      if (s) begin
         if (m_len > 0) err_q.push_back(cur_cyc + 1);
         m_len   = 0;
         m_start = cur_cyc;
      end
      if (s || m_len > 0) begin
         m_bins[nat_index(2 * m_len)]     = a;
         m_bins[nat_index(2 * m_len + 1)] = b;
         m_len++;
         if (m_len == 16) begin
            for (int k = 0; k < 16; k++) begin
               e.cyc   = m_start + 17 + k;
               e.lo    = m_bins[k];
               e.hi    = m_bins[k + 16];
               e.first = (k == 0);
               e.last  = (k == 15);
               exp_q.push_back(e);
            end
            m_len = 0;
         end
      end
   endtask

   // One clock cycle of stimulus: inputs change just after the rising edge that opens the cycle.
   task automatic drive(bit r, bit s, logic [W-1:0] a, logic [W-1:0] b);
      @(posedge clk);
      #1;
      cur_cyc++;
      rst_n    = r;
      in_start = s;
      in_a     = a;
      in_b     = b;
      if (!r) begin
         m_len = 0;
         exp_q.delete();
         err_q.delete();
      end else begin
         model_step(s, a, b);
      end
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) drive(1'b1, 1'b0, '0, '0);
   endtask

   task automatic rand_frame();
      for (int j = 0; j < 16; j++) drive(1'b1, j == 0, W'($urandom()), W'($urandom()));
   endtask

   always @(negedge clk) begin
      if (out_valid) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_out cyc=%0d got lo=%h hi=%h, required no output", cur_cyc, out_lo, out_hi);
         end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.cyc != cur_cyc || out_lo != mon_e.lo || out_hi != mon_e.hi ||
                out_first != mon_e.first || out_last != mon_e.last) begin
               n_fail++;
               $display("FAIL out_pair cyc=%0d got lo=%h hi=%h f=%0b l=%0b, required cyc=%0d lo=%h hi=%h f=%0b l=%0b",
                        cur_cyc, out_lo, out_hi, out_first, out_last,
                        mon_e.cyc, mon_e.lo, mon_e.hi, mon_e.first, mon_e.last);
            end
         end
      end else begin
         n_tests++;
         if (out_lo != '0 || out_hi != '0 || out_first || out_last) begin
            n_fail++;
            $display("FAIL idle_zero cyc=%0d got lo=%h hi=%h f=%0b l=%0b, required all 0",
                     cur_cyc, out_lo, out_hi, out_first, out_last);
         end
         if (exp_q.size() > 0 && exp_q[0].cyc <= cur_cyc) begin
            n_tests++;
            n_fail++;
            mon_e = exp_q.pop_front();
            $display("FAIL missing_out cyc=%0d got out_valid=0, required pair lo=%h hi=%h due at cyc %0d",
                     cur_cyc, mon_e.lo, mon_e.hi, mon_e.cyc);
         end
      end

      n_tests++;
      if (frame_err) begin
         if (err_q.size() > 0 && err_q[0] == cur_cyc) begin
            void'(err_q.pop_front());
         end else begin
            n_fail++;
            $display("FAIL frame_err cyc=%0d got 1, required 0", cur_cyc);
         end
      end else if (err_q.size() > 0 && err_q[0] <= cur_cyc) begin
         n_fail++;
         $display("FAIL frame_err cyc=%0d got 0, required 1 (due cyc %0d)", cur_cyc, err_q[0]);
         void'(err_q.pop_front());
      end
   end

   initial begin
      // Reset held for a few cycles; the monitor checks all outputs stay 0.
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, '0, '0);
      idle(2);

      // Single frame with in_a=j, in_b=j+16.
      for (int j = 0; j < 16; j++) drive(1'b1, j == 0, W'(j), W'(j + 16));
      idle(25);

      // Three back-to-back frames.
      for (int f = 0; f < 3; f++) rand_frame();
      idle(30);

      // Restart at j=7: first frame discarded.
      for (int j = 0; j < 7; j++) drive(1'b1, j == 0, W'($urandom()), W'($urandom()));
      rand_frame();
      idle(30);

      // Restart at j=15.
      for (int j = 0; j < 15; j++) drive(1'b1, j == 0, W'($urandom()), W'($urandom()));
      rand_frame();
      idle(30);

      // Second frame 40 cycles after the first.
      rand_frame();
      idle(24);
      rand_frame();
      idle(30);

      // Reset at cycle 20 of a frame, i.e. while its output is streaming.
      rand_frame();
      idle(4);
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, '0, '0);
      idle(25);
      rand_frame();
      idle(30);

      // Randomised mix of back-to-back frames, gaps and restarts.
      for (int i = 0; i < 400; i++) begin
         bit s;
         if (m_len == 0) s = ($urandom_range(0, 1) == 0);
         else            s = ($urandom_range(0, 24) == 0);
         drive(1'b1, s, W'($urandom()), W'($urandom()));
      end
      idle(40);

      n_tests++;
      if (exp_q.size() != 0 || err_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain got %0d pairs / %0d errs outstanding, required 0 / 0", exp_q.size(), err_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/fft_output_reorder.md
FFT_OUTPUT_REORDER -- requirements
Module: fft_output_reorder

Interface
REQ-001 Parameter: DW, default 16, bit width of each real and imaginary component.
REQ-002 Port: clk  in  1  clock; all state changes on the rising edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Port: in_start  in  1  frame-start pulse from the FFT controller (valid_ping_pong_in); marks input cycle 0.
REQ-005 Port: in_a  in  2*DW  MDC upper-path output, {re,im}.
REQ-006 Port: in_b  in  2*DW  MDC lower-path output, {re,im}.
REQ-007 Port: out_valid  out  1  out_lo/out_hi carry a valid natural-order pair.
REQ-008 Port: out_lo  out  2*DW  bin X[k], k=0..15.
REQ-009 Port: out_hi  out  2*DW  bin X[k+16].
REQ-010 Port: out_first  out  1  high with k=0.
REQ-011 Port: out_last  out  1  high with k=15.
REQ-012 Port: frame_err  out  1  one-cycle pulse when a partial frame is discarded.

Function
REQ-013 A frame spans 16 consecutive input cycles j=0..15, where j=0 is the cycle in_start is high; in_a and in_b are sampled on every cycle of the frame.
REQ-014 Input mapping: at cycle j, in_a is bin rev4(j) and in_b is bin rev4(j)+16 (5-bit bit-reversal of 2j and 2j+1).
REQ-015 Storage: two ping-pong banks, each with a lo half and a hi half of 16 x 2*DW.
- in_a is written to lo[rev4(j)].
- in_b is written to hi[rev4(j)].
REQ-016 Write FSM: IDLE -> WRITE on in_start; WRITE -> IDLE after j=15 unless in_start is high on the next cycle, in which case it stays in WRITE with j=0.
REQ-017 At the end of a frame (j=15 written) the write bank toggles and that frame is handed to the read side on the same edge.
REQ-018 Read FSM: IDLE -> READ on hand-off; reads k=0..15 on consecutive cycles, reading lo[k] and hi[k] of the finished bank; READ -> IDLE after k=15 unless a new hand-off coincides, in which case it continues with k=0 from the other bank.
REQ-019 Outputs are registered: the read address for k appears on the outputs 1 cycle later.
- in_start at cycle 0 gives out_first at cycle 17; out_last at cycle 32.
REQ-020 Back-to-back frames (in_start every 16 cycles) produce a gapless output stream with out_valid held high.
REQ-021 in_start while WRITE with j!=0 (including j=15):
- partial frame discarded; write restarts at j=0 in the same bank;
- bank not toggled; no hand-off;
- frame_err pulses the next cycle.
REQ-022 When out_valid is low, out_lo, out_hi, out_first and out_last are 0.
REQ-023 Data passes bit-exact; no arithmetic or scaling.
REQ-024 Read-before-overwrite is guaranteed: frame n+1 writes the bank opposite to the one being read for frame n.

Reset
REQ-025 On rst_n low:
- both FSMs go to IDLE; j, k and the bank selects go to 0;
- all outputs go to 0.
REQ-026 Reset mid-frame aborts both the write and read in progress with no further output; bank contents are not cleared and are don't-care.
REQ-027 Reset release is synchronous-safe: the first in_start accepted is the one sampled on the first rising edge with rst_n high.

Structure
REQ-028 The shared package fft32_pkg holds N=32, HALF=16, LOG2N=5, the 4-bit bit-reverse function, and the read/write FSM state enum.
REQ-029 One sub-module, fft_pp_half_bank:
- 16 x 2*DW, one synchronous write port and one registered read port;
- instantiated four times (2 banks x lo/hi).

Verification
REQ-030 Single frame: in_a=j, in_b=j+16 on cycles 0..15 -> cycles 17..32 give out_lo=rev4(k) and out_hi=rev4(k)+16, out_first at 17, out_last at 32.
REQ-031 Three back-to-back frames with in_start at 0, 16 and 32 -> out_valid high continuously on cycles 17..64, and each frame's data is correct with no bank crosstalk.
REQ-032 in_start at cycles 0 and 7 -> frame_err pulse at cycle 8; output starts at cycle 24 holding only the second frame's data.
REQ-033 Reset asserted at cycle 20 of a single frame -> all outputs 0 immediately; no output after release until a new in_start plus 17 cycles.
REQ-034 in_start at cycle 0 then at cycle 40 (gap) -> out_valid low on cycles 33..56, then the second frame appears on cycles 57..72.
REQ-035 in_start at cycle 15 of a frame -> frame_err pulse; no hand-off of the first frame.
